// File: rtl/fetch_pc_unit_if.sv
// Fetch-side bus bundle: instruction-memory request/response channel plus
// the fetched-instruction handshake towards decode.
//   master : the fetch unit (drives request, address and instruction outputs)
//   slave  : memory + decode side (drives grant, read data and decode_ready)
// Signals:
//   imem_req / imem_addr           fetch request and word address
//   imem_gnt                       memory accepted the request this cycle
//   imem_rvalid / imem_rdata       read response
//   instr_valid / instr / instr_pc fetched instruction and its address
//   decode_ready                   decode accepts instr when instr_valid=1
interface fetch_pc_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        decode_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output instr_valid,
    output instr,
    output instr_pc,
    input  decode_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output decode_ready
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program-counter register and instruction-fetch sequencer.
// Holds the architectural PC, issues one instruction-memory request at a time
// and presents each fetched word to decode via a valid/ready handshake.
// Redirects from execute take priority in every state and flush in-flight work;
// a response still outstanding at redirect time is drained and discarded.
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-low reset
//   pc_out         current PC, feeds PC adder operand a (b tied to 4)
//   pc_plus4       PC adder result (pc_out + 4, modulo 2^32)
//   redirect_valid one-cycle redirect request from execute
//   redirect_pc    redirect target
//   misalign_err   registered one-cycle pulse when redirect_pc[1:0] != 0
//   bus            fetch_pc_unit_if master modport (imem + decode handshake)
// All outputs are registers or decoded from the state register.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [31:0]            pc_out,
  input  logic [31:0]            pc_plus4,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   misalign_err,
  fetch_pc_unit_if.master        bus
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StReq  = 3'd1,
    StWait = 3'd2,
    StHold = 3'd3,
    StDrop = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        misalign_q, misalign_d;

  logic [31:0] redirect_tgt;

  // Target is forced to word alignment; the misalignment is reported separately.
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      instr_q    <= Nop;
      instr_pc_q <= 32'h0000_0000;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    misalign_d = 1'b0;

    if (redirect_valid) begin
      pc_d       = redirect_tgt;
      addr_d     = redirect_tgt;
      misalign_d = (redirect_pc[1:0] != 2'b00);
      unique case (state_q)
        StIdle:  state_d = StReq;
        // A grant in the same cycle leaves a response in flight that must be drained.
        StReq:   state_d = bus.imem_gnt ? StDrop : StReq;
        StWait:  state_d = bus.imem_rvalid ? StReq : StDrop;
        StHold:  state_d = StReq;
        StDrop:  state_d = bus.imem_rvalid ? StReq : StDrop;
        default: state_d = StIdle;
      endcase
    end else begin
      unique case (state_q)
        StIdle: state_d = StReq;
        StReq: begin
          if (bus.imem_gnt) state_d = StWait;
        end
        StWait: begin
          if (bus.imem_rvalid) begin
            instr_d    = bus.imem_rdata;
            instr_pc_d = pc_q;
            pc_d       = pc_plus4;
            state_d    = StHold;
          end
        end
        StHold: begin
          if (bus.decode_ready) begin
            addr_d  = pc_q;
            state_d = StReq;
          end
        end
        StDrop: begin
          if (bus.imem_rvalid) state_d = StReq;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign pc_out          = pc_q;
  assign misalign_err    = misalign_q;
  assign bus.imem_req    = (state_q == StReq);
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = (state_q == StHold);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a zero-wait memory model returning the
// address as data (switchable to manual control), the PC adder, and one task
// per scenario with hand-computed expectations.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        misalign_err;

  logic        mem_auto = 1'b1;
  logic        gnt_man = 1'b0;
  logic        rv_man = 1'b0;
  logic [31:0] rd_man = 32'h0;
  logic        ready = 1'b1;
  logic        rv_q = 1'b0;
  logic [31:0] rd_q = 32'h0;

  int n_checks = 0;
  int n_pass = 0;

  fetch_pc_unit_if bus ();

  fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_out         (pc_out),
    .pc_plus4       (pc_plus4),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign_err   (misalign_err),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  assign pc_plus4         = pc_out + 32'd4;
  assign bus.imem_gnt     = mem_auto ? bus.imem_req : gnt_man;
  assign bus.imem_rvalid  = mem_auto ? rv_q : rv_man;
  assign bus.imem_rdata   = mem_auto ? rd_q : rd_man;
  assign bus.decode_ready = ready;

  // Zero-wait memory: data (= address) one cycle after the granted request.
  always @(posedge clk) begin
    if (!rst) begin
      rv_q <= 1'b0;
      rd_q <= 32'h0;
    end else begin
      rv_q <= mem_auto & bus.imem_req & bus.imem_gnt;
      rd_q <= bus.imem_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({pc_out, bus.imem_addr} !== 64'h0) begin
      $display("FAIL reset_pc: got pc %h addr %h want 0/0", pc_out, bus.imem_addr);
    end else n_pass++;
    n_checks++;
    if ({bus.imem_req, bus.instr_valid, misalign_err} !== 3'b000) begin
      $display("FAIL reset_ctl: got req/valid/mis %b%b%b want 000",
               bus.imem_req, bus.instr_valid, misalign_err);
    end else n_pass++;
    n_checks++;
    if (bus.instr !== 32'h0000_0013 || bus.instr_pc !== 32'h0) begin
      $display("FAIL reset_instr: got %h @ %h want 00000013 @ 0", bus.instr, bus.instr_pc);
    end else n_pass++;
  endtask

  // Edges 1..9 after release: req at e%3==1, valid at e%3==0 with instr 4(k-1).
  task automatic test_sequential();
    rst = 1'b1;
    ready = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      n_checks++;
      if (bus.instr_valid !== (e % 3 == 0) || bus.imem_req !== (e % 3 == 1)) begin
        $display("FAIL seq_ctl e%0d: got valid %b req %b", e, bus.instr_valid, bus.imem_req);
      end else n_pass++;
      if (e % 3 == 0) begin
        n_checks++;
        if (bus.instr !== 32'(4 * (e / 3 - 1)) || bus.instr_pc !== 32'(4 * (e / 3 - 1)) ||
            pc_out !== 32'(4 * (e / 3))) begin
          $display("FAIL seq_data e%0d: got instr %h pc %h pc_out %h want %h/%h/%h", e,
                   bus.instr, bus.instr_pc, pc_out, 4 * (e / 3 - 1), 4 * (e / 3 - 1), 4 * (e / 3));
        end else n_pass++;
      end
    end
  endtask

  task automatic test_stall();
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h8 || bus.instr_pc !== 32'h8 ||
          bus.imem_req !== 1'b0 || pc_out !== 32'hC) begin
        $display("FAIL stall c%0d: got valid %b instr %h ipc %h req %b pc %h", i,
                 bus.instr_valid, bus.instr, bus.instr_pc, bus.imem_req, pc_out);
      end else n_pass++;
    end
    ready = 1'b1;
    tick();
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC) begin
      $display("FAIL stall_release: got req %b addr %h want 1/0000000c",
               bus.imem_req, bus.imem_addr);
    end else n_pass++;
    tick();
    tick();
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'hC || bus.instr !== 32'hC) begin
      $display("FAIL stall_next: got valid %b instr %h @ %h want 1 0000000c @ 0000000c",
               bus.instr_valid, bus.instr, bus.instr_pc);
    end else n_pass++;
  endtask

  task automatic test_redirect_wait();
    tick();                       // Hold -> Req (addr 0x10)
    mem_auto = 1'b0;
    gnt_man  = 1'b1;
    tick();                       // Req -> Wait
    gnt_man        = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();                       // Wait -> Drop
    redirect_valid = 1'b0;
    n_checks++;
    if (pc_out !== 32'h100 || bus.imem_addr !== 32'h100 || bus.imem_req !== 1'b0 ||
        misalign_err !== 1'b0) begin
      $display("FAIL rw_redirect: got pc %h addr %h req %b mis %b want 100/100/0/0",
               pc_out, bus.imem_addr, bus.imem_req, misalign_err);
    end else n_pass++;
    tick();                       // still Drop
    n_checks++;
    if (bus.imem_req !== 1'b0) begin
      $display("FAIL rw_drop_wait: got req %b want 0", bus.imem_req);
    end else n_pass++;
    rv_man = 1'b1;
    rd_man = 32'hDEAD_BEEF;
    tick();                       // Drop -> Req, data discarded
    rv_man = 1'b0;
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || bus.instr !== 32'hC ||
        bus.instr_valid !== 1'b0 || pc_out !== 32'h100) begin
      $display("FAIL rw_dropped: got req %b addr %h instr %h valid %b pc %h",
               bus.imem_req, bus.imem_addr, bus.instr, bus.instr_valid, pc_out);
    end else n_pass++;
    mem_auto = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h100 || bus.instr !== 32'h100 ||
        pc_out !== 32'h104) begin
      $display("FAIL rw_refetch: got valid %b instr %h @ %h pc %h want 1 100 @ 100 pc 104",
               bus.instr_valid, bus.instr, bus.instr_pc, pc_out);
    end else n_pass++;
  endtask

  task automatic test_redirect_hold();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0202;
    tick();                       // Hold -> Req despite decode_ready
    redirect_valid = 1'b0;
    n_checks++;
    if (misalign_err !== 1'b1 || bus.imem_addr !== 32'h200 || bus.instr_valid !== 1'b0 ||
        bus.imem_req !== 1'b1 || bus.instr_pc !== 32'h100) begin
      $display("FAIL rh_redirect: got mis %b addr %h valid %b req %b ipc %h",
               misalign_err, bus.imem_addr, bus.instr_valid, bus.imem_req, bus.instr_pc);
    end else n_pass++;
    tick();
    n_checks++;
    if (misalign_err !== 1'b0) begin
      $display("FAIL rh_pulse: got mis %b want 0", misalign_err);
    end else n_pass++;
    tick();
    n_checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h200) begin
      $display("FAIL rh_fetch: got valid %b ipc %h want 1/00000200",
               bus.instr_valid, bus.instr_pc);
    end else n_pass++;
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (bus.imem_addr !== 32'hFFFF_FFFC || misalign_err !== 1'b0) begin
      $display("FAIL wrap_redirect: got addr %h mis %b want fffffffc/0",
               bus.imem_addr, misalign_err);
    end else n_pass++;
    tick();
    tick();
    n_checks++;
    if (bus.instr_pc !== 32'hFFFF_FFFC || pc_out !== 32'h0) begin
      $display("FAIL wrap_pc: got ipc %h pc %h want fffffffc/0", bus.instr_pc, pc_out);
    end else n_pass++;
    tick();
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      $display("FAIL wrap_addr: got req %b addr %h want 1/0", bus.imem_req, bus.imem_addr);
    end else n_pass++;
  endtask

  task automatic test_reset_mid();
    tick();                       // Req -> Wait, response pending
    rst = 1'b0;
    tick();
    n_checks++;
    if (pc_out !== 32'h0 || bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b0 ||
        bus.instr_valid !== 1'b0 || bus.instr !== 32'h13 || bus.instr_pc !== 32'h0 ||
        misalign_err !== 1'b0) begin
      $display("FAIL mid_reset: got pc %h addr %h req %b valid %b instr %h ipc %h mis %b",
               pc_out, bus.imem_addr, bus.imem_req, bus.instr_valid, bus.instr,
               bus.instr_pc, misalign_err);
    end else n_pass++;
    rst = 1'b1;
    tick();
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      $display("FAIL mid_release: got req %b addr %h want 1/0", bus.imem_req, bus.imem_addr);
    end else n_pass++;
  endtask

  // In S_REQ: redirect without grant re-issues; with grant the response is drained.
  task automatic test_back_to_back();
    mem_auto       = 1'b0;
    gnt_man        = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    tick();
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
      $display("FAIL req_nognt: got req %b addr %h want 1/00000040",
               bus.imem_req, bus.imem_addr);
    end else n_pass++;
    gnt_man     = 1'b1;
    redirect_pc = 32'h0000_0080;
    tick();
    redirect_valid = 1'b0;
    gnt_man        = 1'b0;
    n_checks++;
    if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h80 || pc_out !== 32'h80) begin
      $display("FAIL req_gnt: got req %b addr %h pc %h want 0/80/80",
               bus.imem_req, bus.imem_addr, pc_out);
    end else n_pass++;
    rv_man = 1'b1;
    rd_man = 32'h1234_5678;
    tick();
    rv_man = 1'b0;
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h80 || bus.instr !== 32'h13) begin
      $display("FAIL req_drain: got req %b addr %h instr %h want 1/80/00000013",
               bus.imem_req, bus.imem_addr, bus.instr);
    end else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
